// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Brief  : Operation/state encodings and decode helpers for the muldiv unit.
// Rev    : 1.0
// ============================================================================
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic a_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic b_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_divider.sv
`default_nettype none
// ============================================================================
// Module : iter_divider
// Brief  : One combinational restoring-division step on unsigned magnitudes.
// Rev    : 1.0
// ============================================================================
module iter_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // The dividend sits in the quotient register and shifts out MSB-first.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {2'b00, div_i};
    if (!diff[XLEN+1]) begin
      rem_o = diff[XLEN:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative RV32M multiply/divide unit with valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              CNT_W   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q;
  md_op_e          op_q;
  logic            neg_q;
  logic            out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]   acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;

  md_op_e          op_in;
  logic            sa, sb, neg_in, div_zero, div_ovf, fast_in, special_in;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN:0]   mul_sum, acc_d, div_rem;
  logic [XLEN-1:0] lo_d, div_quo, div_sel, fin_res;

  function automatic logic [XLEN-1:0] mul_half(input logic [2*XLEN-1:0] prod,
                                               input logic neg, input md_op_e mop);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (mop == MD_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign op_in = md_op_e'(op);
  assign sa    = a_signed(op_in) & src_a[XLEN-1];
  assign sb    = b_signed(op_in) & src_b[XLEN-1];
  assign a_mag = sa ? -src_a : src_a;
  assign b_mag = sb ? -src_b : src_b;

  generate
    if (FAST_MUL) begin : g_fast_mul
      assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    end else begin : g_iter_mul
      assign fast_prod = '0;
    end
  endgenerate

  iter_divider #(.XLEN(XLEN)) u_div (
    .rem_i (acc_q),
    .quo_i (lo_q),
    .div_i (b_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  always_comb begin
    neg_in     = is_rem(op_in) ? sa : (sa ^ sb);
    div_zero   = is_div(op_in) && (src_b == '0);
    div_ovf    = ((op_in == MD_DIV) || (op_in == MD_REM)) && (src_a == INT_MIN) && (&src_b);
    fast_in    = FAST_MUL && !is_div(op_in);
    special_in = div_zero || div_ovf || fast_in;
    if (div_zero)     special_res = op_in[1] ? src_a : '1;
    else if (div_ovf) special_res = op_in[1] ? '0 : INT_MIN;
    else              special_res = mul_half(fast_prod, neg_in, op_in);

    // Shift-add: acc holds the running high half, lo shifts multiplier out / product in.
    mul_sum = {1'b0, acc_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, b_q} : '0);
    if (is_div(op_q)) begin
      acc_d = div_rem;
      lo_d  = div_quo;
    end else begin
      acc_d = {1'b0, mul_sum[XLEN:1]};
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    div_sel = op_q[1] ? div_rem[XLEN-1:0] : div_quo;
    if (is_div(op_q)) fin_res = neg_q ? -div_sel : div_sel;
    else              fin_res = mul_half({acc_d[XLEN-1:0], lo_d}, neg_q, op_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= MD_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (in_valid && in_ready) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            if (special_in) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= MD_DONE;
            end else begin
              acc_q   <= '0;
              lo_q    <= is_div(op_in) ? a_mag : b_mag;
              b_q     <= is_div(op_in) ? b_mag : a_mag;
              cnt_q   <= CNT_W'(XLEN);
              state_q <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= fin_res;
            out_valid_q <= 1'b1;
            state_q     <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= MD_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= MD_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == MD_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = (state_q != MD_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Directed scoreboard bench for muldiv_unit (XLEN=32, iterative multiply).
// Rev    : 1.0
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        flush     = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op        = 3'b000;
  logic [31:0] src_a     = 32'h0;
  logic [31:0] src_b     = 32'h0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   first_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake and checks value and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!out_valid) begin
      first_cyc = -1;
    end else begin
      if (first_cyc < 0) first_cyc = cyc;
      if (out_ready && !rst && !flush) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got 0x%08h, required no output", result);
        end else begin
          e = sb_q.pop_front();
          check(e.name, result, e.res);
          check({e.name, "_latency"}, 32'(first_cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name, input bit push);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_issue: in_ready=0, required 1", name);
      return;
    end
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    if (push) sb_q.push_back('{res: exp, lat: lat, acc: cyc, name: name});
    @(posedge clk); #1;
    // Garbage after accept: the unit must have latched its operands.
    in_valid = 1'b0; op = 3'b011; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_wait: out_valid=0, required 1", name);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    issue(MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3",     1'b1);
    issue(MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "mulh_min_min", 1'b1);
    issue(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max",    1'b1);
    issue(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1",    1'b1);
    issue(MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div_m7_2",     1'b1);
    issue(MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2",     1'b1);
    issue(MD_DIVU,   32'd100,        32'd7,         32'd14,        33, "divu_100_7",   1'b1);
    issue(MD_REMU,   32'd100,        32'd7,         32'd2,         33, "remu_100_7",   1'b1);
    issue(MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF,  1, "div_by_zero",  1'b1);
    issue(MD_REMU,   32'd5,          32'd0,         32'd5,          1, "remu_by_zero", 1'b1);
    issue(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1, "div_ovf",      1'b1);
    issue(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          1, "rem_ovf",      1'b1);
    drain();

    // Backpressure in DONE.
    out_ready = 1'b0;
    issue(MD_DIVU, 32'd100, 32'd7, 32'd14, 33, "bp_divu", 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_result_hold", result,          32'd14);
      check("bp_in_ready",    32'(in_ready),   32'd0);
      check("bp_out_valid",   32'(out_valid),  32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Flush mid-CALC with a competing request in the same cycle.
    issue(MD_DIVU, 32'd50, 32'd5, 32'd10, 33, "flushed", 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1; in_valid = 1'b1; op = MD_DIVU; src_a = 32'd9; src_b = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy",      32'(busy),      32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    issue(MD_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3", 1'b1);
    drain();

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    issue(MD_DIVU, 32'd100, 32'd7, 32'd14, 33, "rst_done", 1'b0);
    wait_valid("rst_done");
    check("rst_done_result_before", result, 32'd14);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_done_out_valid", 32'(out_valid), 32'd0);
    check("rst_done_result",    result,         32'd0);
    check("rst_done_busy",      32'(busy),      32'd0);
    check("rst_done_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_done_release_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
